// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with selectable read mode, programmable thresholds,
// fill level and sticky overflow/underflow flags.
module sync_fifo_flex #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_L    = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   AE_L    = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LVL_ONE = (ADDR_WIDTH+1)'(1);

    if (AFULL_THRESH <= 0 || AFULL_THRESH > DEPTH ||
        AEMPTY_THRESH < 0 || AEMPTY_THRESH >= DEPTH) begin : g_bad_param
        $error("sync_fifo_flex: illegal AFULL_THRESH/AEMPTY_THRESH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  push_ok, pop_ok;

    assign empty        = (level_q == '0);
    assign full         = (level_q == DEPTH_L);
    assign almost_empty = (level_q <= AE_L);
    assign almost_full  = (level_q >= AF_L);
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // A full FIFO still takes a write when the same cycle frees a slot.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        unique case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (push && !push_ok) ovf_d = 1'b1;
        if (pop && !pop_ok)   udf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !reset) mem[wr_ptr_q] <= data_in;
    end

    if (FWFT != 0) begin : g_fwft
        assign data_out = empty ? '0 : mem[rd_ptr_q];
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = dout_q;
            if (pop_ok) dout_d = mem[rd_ptr_q];
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) dout_q <= '0;
            else       dout_q <= dout_d;
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: registered and FWFT instances driven in lockstep
// against a queue-based reference model through an expectation scoreboard.
module tb_sync_fifo_flex;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data_in = '0;

    logic [7:0] dout0, dout1;
    logic       emp0, ful0, ae0, af0, ov0, un0;
    logic       emp1, ful1, ae1, af1, ov1, un1;
    logic [4:0] lvl0, lvl1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int lvl;
        bit emp, ful, ae, af, ov, un;
        int d0, d1;
    } exp_t;

    exp_t exp_q[$];
    int   mq[$];
    bit   m_ov, m_un;
    int   m_d0;

    sync_fifo_flex #(.FWFT(0)) u_reg (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in),
        .pop(pop), .data_out(dout0), .empty(emp0), .full(ful0),
        .almost_empty(ae0), .almost_full(af0), .level(lvl0),
        .overflow(ov0), .underflow(un0), .clr_err(clr_err)
    );

    sync_fifo_flex #(.FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in),
        .pop(pop), .data_out(dout1), .empty(emp1), .full(ful1),
        .almost_empty(ae1), .almost_full(af1), .level(lvl1),
        .overflow(ov1), .underflow(un1), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, expv, $time);
        end
    endtask

    function automatic void model_step(input bit ps, input int d,
                                       input bit pp, input bit cl);
        bit   was_full, was_empty, push_ok, pop_ok;
        exp_t e;
        was_full  = (mq.size() == 16);
        was_empty = (mq.size() == 0);
        push_ok   = ps && (!was_full || pp);
        pop_ok    = pp && !was_empty;
        if (pop_ok) m_d0 = mq.pop_front();
        if (push_ok) mq.push_back(d);
        if (cl) begin
            m_ov = 0;
            m_un = 0;
        end
        if (ps && !push_ok) m_ov = 1;
        if (pp && !pop_ok)  m_un = 1;
        e.lvl = mq.size();
        e.emp = (mq.size() == 0);
        e.ful = (mq.size() == 16);
        e.ae  = (mq.size() <= 2);
        e.af  = (mq.size() >= 14);
        e.ov  = m_ov;
        e.un  = m_un;
        e.d0  = m_d0;
        e.d1  = (mq.size() == 0) ? 0 : mq[0];
        exp_q.push_back(e);
    endfunction

    task automatic cycle(input bit ps, input int d, input bit pp,
                         input bit cl);
        @(negedge clk);
        push    = ps;
        data_in = d[7:0];
        pop     = pp;
        clr_err = cl;
        @(posedge clk);
        model_step(ps, d, pp, cl);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_level"}, {27'd0, lvl0}, 0);
        chk({tag, "_empty"}, {31'd0, emp0}, 1);
        chk({tag, "_aempty"}, {31'd0, ae0}, 1);
        chk({tag, "_full"}, {31'd0, ful0}, 0);
        chk({tag, "_afull"}, {31'd0, af0}, 0);
        chk({tag, "_ovf"}, {31'd0, ov0}, 0);
        chk({tag, "_udf"}, {31'd0, un0}, 0);
        chk({tag, "_dout_reg"}, {24'd0, dout0}, 0);
        chk({tag, "_dout_fwft"}, {24'd0, dout1}, 0);
        chk({tag, "_level_fwft"}, {27'd0, lvl1}, 0);
        chk({tag, "_empty_fwft"}, {31'd0, emp1}, 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("level", {27'd0, lvl0}, e.lvl);
                chk("empty", {31'd0, emp0}, {31'd0, e.emp});
                chk("full", {31'd0, ful0}, {31'd0, e.ful});
                chk("almost_empty", {31'd0, ae0}, {31'd0, e.ae});
                chk("almost_full", {31'd0, af0}, {31'd0, e.af});
                chk("overflow", {31'd0, ov0}, {31'd0, e.ov});
                chk("underflow", {31'd0, un0}, {31'd0, e.un});
                chk("dout_reg", {24'd0, dout0}, e.d0);
                chk("level_fwft", {27'd0, lvl1}, e.lvl);
                chk("empty_fwft", {31'd0, emp1}, {31'd0, e.emp});
                chk("overflow_fwft", {31'd0, ov1}, {31'd0, e.ov});
                chk("underflow_fwft", {31'd0, un1}, {31'd0, e.un});
                chk("dout_fwft", {24'd0, dout1}, e.d1);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bit ps, pp;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) cycle(1, i, 0, 0);
        cycle(1, 'hAA, 0, 0);
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 16; i++) cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 1);

        for (int i = 0; i < 16; i++) cycle(1, $urandom_range(0, 255), 0, 0);
        cycle(1, 'h55, 1, 0);
        for (int i = 0; i < 16; i++) cycle(0, 0, 1, 0);
        cycle(1, 'h66, 1, 0);
        cycle(0, 0, 1, 1);

        cycle(1, 'h3C, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);

        for (int i = 0; i < 8; i++) cycle(1, $urandom_range(0, 255), 0, 0);
        for (int i = 0; i < 40; i++) begin
            ps = 1'($urandom);
            pp = 1'($urandom);
            if (mq.size() >= 12) ps = 0;
            if (mq.size() <= 5)  pp = 0;
            cycle(ps, $urandom_range(0, 255), pp, 0);
        end

        @(negedge clk);
        push    = 1'b1;
        pop     = 1'b0;
        data_in = 8'h99;
        #2 reset = 1'b1;
        #1;
        check_reset("mid_reset");
        exp_q.delete();
        mq.delete();
        m_ov = 0;
        m_un = 0;
        m_d0 = 0;
        @(posedge clk);
        #1;
        check_reset("reset_hold");
        @(negedge clk);
        reset = 1'b0;
        push  = 1'b0;

        for (int i = 0; i < 12; i++)
            cycle(1'($urandom), $urandom_range(0, 255), 1'($urandom), 0);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Parametrised single-clock FIFO with real storage. Adds four things to the basic counter FIFO:
- selectable read mode (registered or first-word-fall-through),
- programmable almost-full / almost-empty thresholds,
- a fill-level output,
- sticky overflow/underflow error flags.

It is the standard buffering primitive between producer/consumer blocks in the datapath.

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 4, pointer width; depth = 2**ADDR_WIDTH
FWFT, 0, read mode: 0 = registered read (data one cycle after pop), 1 = first-word-fall-through
AFULL_THRESH, 2**ADDR_WIDTH-2, almost_full asserts when level >= this value
AEMPTY_THRESH, 2, almost_empty asserts when level <= this value

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
push  in  1  write request
data_in  in  DATA_WIDTH  write data
pop  in  1  read request
data_out  out  DATA_WIDTH  read data
empty  out  1  level == 0
full  out  1  level == 2**ADDR_WIDTH
almost_empty  out  1  level <= AEMPTY_THRESH
almost_full  out  1  level >= AFULL_THRESH
level  out  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH
overflow  out  1  sticky: push rejected while full
underflow  out  1  sticky: pop rejected while empty
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Clock and reset: reset is asynchronous and active-high; clock is clk.
- On reset:
  - rd_ptr, wr_ptr and level go to 0.
  - data_out = 0, overflow = 0, underflow = 0.
  - Hence empty = 1, almost_empty = 1, full = 0, almost_full = 0 (assuming AFULL_THRESH > 0).
  - Memory contents are not reset.
- Flags are a combinational decode of the registered level. They reflect state after the most recent edge; no extra cycle of lag.
- Accept rules, evaluated on each rising edge:
  - push_ok = push && (!full || pop). A push on a full FIFO is accepted when a pop happens in the same cycle.
  - pop_ok = pop && !empty. A pop on an empty FIFO is never accepted, even if a push happens in the same cycle.
- Pointer and level updates:
  - push_ok: mem[wr_ptr] <= data_in; wr_ptr increments.
  - pop_ok: rd_ptr increments.
  - level: +1 if push_ok only; -1 if pop_ok only; unchanged if both or neither.
  - Pointers wrap modulo 2**ADDR_WIDTH with natural binary rollover. level never exceeds 2**ADDR_WIDTH and never goes below 0.
- Error flags:
  - push && !push_ok sets overflow; the data is dropped.
  - pop && !pop_ok sets underflow.
  - Both flags stay set until clr_err or reset. If clr_err and a new error occur in the same cycle, the set wins.
- FWFT = 0 (registered read):
  - On pop_ok, data_out <= mem[rd_ptr] (the oldest word), visible the cycle after the pop.
  - data_out holds its value when there is no accepted pop.
- FWFT = 1 (first-word-fall-through):
  - data_out = mem[rd_ptr] whenever !empty, so the head word is visible with no pop; pop acknowledges/consumes it.
  - data_out = 0 while empty.
  - A word pushed into an empty FIFO appears on data_out in the cycle after the push edge, together with empty deasserting.
- Reset mid-operation: asynchronous return to the reset state; in-flight push/pop in that cycle is discarded.
- Parameter legality:
  - 0 < AFULL_THRESH <= 2**ADDR_WIDTH and 0 <= AEMPTY_THRESH < 2**ADDR_WIDTH.
  - Illegal values are a compile-time error, flagged by an elaboration check.

Test Plan:
1. Reset, then fill (defaults, FWFT=0): push 16 words 0x00..0x0F.
   - level counts 1..16.
   - almost_full rises when level = 14.
   - full = 1 at level 16; almost_empty drops when level = 3.
2. Overflow: with FIFO full, push 0xAA without pop.
   - overflow = 1, level stays 16, 0xAA never appears on read.
   - clr_err pulse returns overflow to 0.
3. Drain, FWFT=0: pop 16 times.
   - data_out = 0x00..0x0F, each one cycle after its pop.
   - empty = 1 after the 16th pop.
   - A 17th pop sets underflow = 1; data_out holds 0x0F.
4. Simultaneous push+pop:
   - At level 16: push 0x55 + pop → level stays 16; 0x55 is read last.
   - At level 0: push 0x66 + pop → pop rejected, underflow = 1, level = 1.
5. FWFT=1 build: push 0x3C into an empty FIFO.
   - Next cycle: empty = 0, data_out = 0x3C with no pop.
   - Pop → data_out = 0, empty = 1.
6. Wrap-around: 40 interleaved push/pop cycles with level kept between 5 and 12.
   - Output sequence equals input sequence; level matches the scoreboard every cycle.
   - Assert reset mid-stream → all outputs go to reset values immediately.
